shift_transfer_controller: RTL

Sequencer that drives the control pins of an external universal shift register (WIDTH bits, 2-bit direction: 00 hold, 01 shift right, 10 shift left, 11 parallel load with load qualifier) to perform full-duplex serial transfers.
- Accepts a command word over a valid/ready handshake, parallel-loads it, then shifts out and in 1..WIDTH bits at a programmable bit rate.
- Returns the captured word over a valid/ready response channel.
- Sits between a host/CSR bus and the shift register datapath.

---
 rtl/shift_transfer_controller_if.sv | 41 ++++
 rtl/shift_transfer_controller.sv | 114 +++++++++++
 2 files changed

// File: rtl/shift_transfer_controller_if.sv
// Bundle for the command/response channels, serial pins and shift-register control pins.
// The controller uses the master modport; the host and shift-register side use slave.
interface shift_transfer_controller_if #(
  parameter int WIDTH = 8
);
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [LEN_W-1:0] cmd_len;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  logic             serial_out;
  logic             serial_out_valid;
  logic             serial_in;

  logic             sr_enable;
  logic [1:0]       sr_direction;
  logic             sr_load;
  logic [WIDTH-1:0] sr_parallel_in;
  logic             sr_serial_in_left;
  logic             sr_serial_in_right;
  logic [WIDTH-1:0] sr_parallel_out;

  modport master (
    input  cmd_valid, cmd_data, cmd_dir, cmd_len, rsp_ready, serial_in, sr_parallel_out,
    output cmd_ready, rsp_valid, rsp_data, serial_out, serial_out_valid,
    output sr_enable, sr_direction, sr_load, sr_parallel_in, sr_serial_in_left, sr_serial_in_right
  );

  modport slave (
    output cmd_valid, cmd_data, cmd_dir, cmd_len, rsp_ready, serial_in, sr_parallel_out,
    input  cmd_ready, rsp_valid, rsp_data, serial_out, serial_out_valid,
    input  sr_enable, sr_direction, sr_load, sr_parallel_in, sr_serial_in_left, sr_serial_in_right
  );
endinterface

// File: rtl/shift_transfer_controller.sv
// Sequences an external universal shift register through load / shift / respond for serial transfers.
// Optional macro SHIFT_CTRL_ABORT_EN adds an abort input that cancels a transfer in LOAD or SHIFT.
module shift_transfer_controller #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input logic clk,
  input logic rst_n,
`ifdef SHIFT_CTRL_ABORT_EN
  input logic abort,
`endif
  shift_transfer_controller_if.master bus
);
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t           r_fsm;
  logic             r_dir;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_data;
  logic [DIV_W-1:0] r_div_cnt;

  logic             w_abort;
  logic             w_tick;
  logic             w_last;
  logic [LEN_W-1:0] w_len_eff;

`ifdef SHIFT_CTRL_ABORT_EN
  assign w_abort = abort && ((r_fsm == S_LOAD) || (r_fsm == S_SHIFT));
`else
  assign w_abort = 1'b0;
`endif

  // Zero and out-of-range lengths both mean a full-width transfer.
  assign w_len_eff = ((bus.cmd_len == '0) || (bus.cmd_len > LEN_MAX)) ? LEN_MAX : bus.cmd_len;
  assign w_tick    = (r_fsm == S_SHIFT) && (r_div_cnt == DIV_LAST);
  assign w_last    = (r_bit_cnt == (r_len - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= S_IDLE;
      r_dir     <= 1'b0;
      r_len     <= '0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_div_cnt <= '0;
    end else if (w_abort) begin
      r_fsm <= S_IDLE;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            r_data <= bus.cmd_data;
            r_dir  <= bus.cmd_dir;
            r_len  <= w_len_eff;
            r_fsm  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          r_fsm     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + LEN_W'(1);
            if (w_last) r_fsm <= S_DONE;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) r_fsm <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  // rst_n gates cmd_ready so the host sees "not ready" for the whole reset pulse.
  always_comb begin
    bus.cmd_ready          = rst_n && (r_fsm == S_IDLE);
    bus.rsp_valid          = (r_fsm == S_DONE);
    bus.rsp_data           = (r_fsm == S_DONE) ? bus.sr_parallel_out : '0;
    bus.serial_out_valid   = (r_fsm == S_SHIFT);
    bus.serial_out         = (r_fsm == S_SHIFT) &&
                             (r_dir ? bus.sr_parallel_out[0] : bus.sr_parallel_out[WIDTH-1]);
    bus.sr_enable          = 1'b0;
    bus.sr_direction       = 2'b00;
    bus.sr_load            = 1'b0;
    bus.sr_parallel_in     = '0;
    bus.sr_serial_in_left  = 1'b0;
    bus.sr_serial_in_right = 1'b0;
    if (!w_abort) begin
      if (r_fsm == S_LOAD) begin
        bus.sr_enable      = 1'b1;
        bus.sr_direction   = 2'b11;
        bus.sr_load        = 1'b1;
        bus.sr_parallel_in = r_data;
      end else if (w_tick) begin
        bus.sr_enable    = 1'b1;
        bus.sr_direction = r_dir ? 2'b01 : 2'b10;
        if (r_dir) bus.sr_serial_in_left  = bus.serial_in;
        else       bus.sr_serial_in_right = bus.serial_in;
      end
    end
  end
endmodule
